// File: rtl/hsid_x_obi_read_master.sv
// OBI read master: fetches a run of consecutive words over OBI and streams them
// downstream through a small FIFO with valid/ready, pulsing obi_done once at the end.
module hsid_x_obi_read_master #(
    parameter int WORD_WIDTH  = 32,
    parameter int LIMIT_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORD_WIDTH-1:0]   obi_initial_addr,
    input  logic [LIMIT_WIDTH-1:0]  obi_limit_in,
    input  logic                    obi_start,
    output logic                    obi_done,
    output logic                    busy,
    output logic                    error,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [WORD_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [WORD_WIDTH/8-1:0] obi_be_o,
    output logic [WORD_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [WORD_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i,
    output logic [WORD_WIDTH-1:0]   data_o,
    output logic                    data_valid_o,
    input  logic                    data_ready_i
);

    localparam int CNT_W = LIMIT_WIDTH + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]        DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [WORD_WIDTH-1:0] ADDR_STEP = WORD_WIDTH'(WORD_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WORD_WIDTH-1:0] addr;
    logic [CNT_W-1:0]      limit;
    logic [CNT_W-1:0]      issued;
    logic [CNT_W-1:0]      delivered;
    logic [CNT_W-1:0]      delivered_next;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        in_flight;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  err_flag;

    logic start_ok;
    logic grant;
    logic resp_live;
    logic push;
    logic stray;
    logic pop;

    assign start_ok  = (state == IDLE) && obi_start;
    assign grant     = obi_req_o && obi_gnt_i;
    // Responses arriving while idle belong to an aborted transfer and are ignored.
    assign resp_live = obi_rvalid_i && (state != IDLE);
    assign push      = resp_live && (outstanding != '0);
    assign stray     = resp_live && (outstanding == '0);
    assign pop       = data_valid_o && data_ready_i;

    assign in_flight      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign delivered_next = delivered + {{(CNT_W-1){1'b0}}, pop};

    always_comb begin
        state_next = state;
        obi_req_o  = 1'b0;
        obi_done   = 1'b0;
        case (state)
            IDLE: begin
                if (obi_start) begin
                    state_next = (obi_limit_in == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                // Granted-but-unanswered words plus buffered words never exceed the
                // FIFO, so every response has a slot; the sum only grows on a grant,
                // which keeps req stable until it is granted.
                obi_req_o = (issued < limit) && (in_flight < DEPTH_C);
                if (issued == limit) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (delivered_next == limit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                obi_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            limit       <= '0;
            issued      <= '0;
            delivered   <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_flag    <= 1'b0;
        end else begin
            state <= state_next;

            if (start_ok) begin
                addr      <= obi_initial_addr;
                limit     <= {1'b0, obi_limit_in};
                issued    <= '0;
                delivered <= '0;
                err_flag  <= 1'b0;
            end else begin
                if (grant) begin
                    addr   <= addr + ADDR_STEP;
                    issued <= issued + CNT_ONE;
                end
                if (pop) begin
                    delivered <= delivered_next;
                end
                if ((push && obi_err_i) || stray) begin
                    err_flag <= 1'b1;
                end
            end

            case ({grant, push})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage carries no reset; emptiness is tracked by fifo_count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= obi_rdata_i;
        end
    end

    assign data_valid_o = (fifo_count != '0);
    assign data_o       = data_valid_o ? mem[rd_ptr] : '0;

    assign busy        = (state != IDLE);
    assign error       = err_flag;
    assign obi_addr_o  = addr;
    assign obi_we_o    = 1'b0;
    assign obi_be_o    = '1;
    assign obi_wdata_o = '0;

endmodule
